// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver
//   Time-multiplexed driver for N_DIGITS common-segment seven-segment digits.
//   Each digit gets a REFRESH_DIV-cycle slot. The first GUARD_CYCLES of every
//   slot keep all digit enables off so the previous digit's segments do not
//   ghost onto the next one. Digit contents are captured into a shadow
//   register on load and copied to the display register only at frame
//   boundaries, so a frame on the pins is never torn. Per-digit blink blanks
//   a digit every other BLINK_FRAMES-frame half-period.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   digits_in   5 bits per digit: 0-15 hex, 16 dash, 17-31 blank
//   dp_in       per-digit decimal point request
//   blink_in    per-digit blink enable
//   load        capture strobe for digits_in / dp_in / blink_in
//   seg         segments {a,b,c,d,e,f,g}, seg[6]=a (pin polarity)
//   dp          decimal point segment (pin polarity)
//   dig_sel     one-hot digit enable, bit k drives digit k (pin polarity)
//   frame_tick  one-cycle pulse while the pins show slot 0 of a new frame

module sevenseg_mux_driver #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 50,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blink_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     dig_sel,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [PW:0]   GUARD_END = (PW+1)'(GUARD_CYCLES);
  localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic          DIG_INV   = (DIG_ACTIVE_LOW != 0);

  logic [PW-1:0]               prescaler;
  logic [IW-1:0]               index;
  logic [BW-1:0]               blink_cnt;
  logic                        blink_phase;

  // packed layout matches digits_in: digit k occupies bits [5k+4:5k]
  logic [N_DIGITS-1:0][4:0]    sh_code;
  logic [N_DIGITS-1:0]         sh_dp;
  logic [N_DIGITS-1:0]         sh_blink;
  logic [N_DIGITS-1:0][4:0]    disp_code;
  logic [N_DIGITS-1:0]         disp_dp;
  logic [N_DIGITS-1:0]         disp_blink;

  logic                        slot_end;
  logic                        frame_end;
  logic                        blanked;
  logic [6:0]                  seg_next;
  logic                        dp_next;
  logic [N_DIGITS-1:0]         dig_next;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'b1111110;
      5'd1:    pat = 7'b0110000;
      5'd2:    pat = 7'b1101101;
      5'd3:    pat = 7'b1111001;
      5'd4:    pat = 7'b0110011;
      5'd5:    pat = 7'b1011011;
      5'd6:    pat = 7'b1011111;
      5'd7:    pat = 7'b1110000;
      5'd8:    pat = 7'b1111111;
      5'd9:    pat = 7'b1111011;
      5'd10:   pat = 7'b1110111;
      5'd11:   pat = 7'b0011111;
      5'd12:   pat = 7'b1001110;
      5'd13:   pat = 7'b0111101;
      5'd14:   pat = 7'b1001111;
      5'd15:   pat = 7'b1000111;
      5'd16:   pat = 7'b0000001;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  assign slot_end  = (prescaler == PRE_LAST);
  assign frame_end = slot_end && (index == IDX_LAST);

  // Next pin values, computed from this cycle's scan state; the registers
  // below give the fixed one-cycle latency to the pins.
  always_comb begin
    blanked  = blink_phase & disp_blink[index];
    seg_next = blanked ? 7'b0000000 : decode(disp_code[index]);
    dp_next  = ~blanked & disp_dp[index];
    dig_next = '0;
    if ({1'b0, prescaler} >= GUARD_END) begin
      dig_next[index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler   <= '0;
      index       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_code     <= '1;
      sh_dp       <= '0;
      sh_blink    <= '0;
      disp_code   <= '1;
      disp_dp     <= '0;
      disp_blink  <= '0;
      seg         <= {7{SEG_INV}};
      dp          <= SEG_INV;
      dig_sel     <= {N_DIGITS{DIG_INV}};
      frame_tick  <= 1'b0;
    end else begin
      if (slot_end) begin
        prescaler <= '0;
        index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // Display takes the shadow as it stood before this edge, so a load
      // coinciding with the boundary lands one frame later.
      if (frame_end) begin
        disp_code  <= sh_code;
        disp_dp    <= sh_dp;
        disp_blink <= sh_blink;
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      if (load) begin
        sh_code  <= digits_in;
        sh_dp    <= dp_in;
        sh_blink <= blink_in;
      end

      seg        <= seg_next ^ {7{SEG_INV}};
      dp         <= dp_next ^ SEG_INV;
      dig_sel    <= dig_next ^ {N_DIGITS{DIG_INV}};
      frame_tick <= (prescaler == '0) && (index == '0);
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Testbench for sevenseg_mux_driver: randomized loads against a cycle-count
// reference model; expected pin values are queued per clock and a separate
// monitor compares them against the DUT.

module tb_sevenseg_mux_driver;

  localparam int N   = 4;
  localparam int RD  = 4;
  localparam int G   = 1;
  localparam int BF  = 2;
  localparam int FR  = N * RD;
  localparam int EW  = 7 + 1 + N + 1;

  logic             clk;
  logic             rst_n;
  logic [5*N-1:0]   digits_in;
  logic [N-1:0]     dp_in;
  logic [N-1:0]     blink_in;
  logic             load;
  logic [6:0]       seg;
  logic             dp;
  logic [N-1:0]     dig_sel;
  logic             frame_tick;

  sevenseg_mux_driver #(
    .N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .blink_in(blink_in), .load(load), .seg(seg), .dp(dp),
    .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // segment table {a..g} indexed by code; 17-31 stay blank
  logic [6:0] dec_tbl [32];
  initial begin
    for (int i = 0; i < 32; i++) dec_tbl[i] = 7'b0000000;
    dec_tbl[0]  = 7'b1111110; dec_tbl[1]  = 7'b0110000;
    dec_tbl[2]  = 7'b1101101; dec_tbl[3]  = 7'b1111001;
    dec_tbl[4]  = 7'b0110011; dec_tbl[5]  = 7'b1011011;
    dec_tbl[6]  = 7'b1011111; dec_tbl[7]  = 7'b1110000;
    dec_tbl[8]  = 7'b1111111; dec_tbl[9]  = 7'b1111011;
    dec_tbl[10] = 7'b1110111; dec_tbl[11] = 7'b0011111;
    dec_tbl[12] = 7'b1001110; dec_tbl[13] = 7'b0111101;
    dec_tbl[14] = 7'b1001111; dec_tbl[15] = 7'b1000111;
    dec_tbl[16] = 7'b0000001;
  end

  // Reference model: t counts cycles since reset release; slot, digit,
  // frame and blink phase all follow from t by plain division.
  int             t = 0;
  logic [5*N-1:0] m_sh_code   = '1;
  logic [N-1:0]   m_sh_dp     = '0;
  logic [N-1:0]   m_sh_blink  = '0;
  logic [5*N-1:0] m_dp_code   = '1;
  logic [N-1:0]   m_dp_dp     = '0;
  logic [N-1:0]   m_dp_blink  = '0;
  logic [EW-1:0]  exp_q [$];

  int             m_f, m_idx, m_pre;
  logic [4:0]     m_c;
  logic [6:0]     m_pat;
  logic           m_dv;
  logic [N-1:0]   m_dig;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.push_back({7'b1111111, 1'b1, {N{1'b0}}, 1'b0});
      t          = 0;
      m_sh_code  = '1; m_sh_dp = '0; m_sh_blink = '0;
      m_dp_code  = '1; m_dp_dp = '0; m_dp_blink = '0;
    end else begin
      m_f   = t / FR;
      m_idx = (t / RD) % N;
      m_pre = t % RD;
      m_c   = m_dp_code[5*m_idx +: 5];
      m_pat = dec_tbl[m_c];
      m_dv  = m_dp_dp[m_idx];
      if (((m_f / BF) % 2 == 1) && m_dp_blink[m_idx]) begin
        m_pat = 7'b0000000;
        m_dv  = 1'b0;
      end
      m_dig = (m_pre < G) ? '0 : N'(1 << m_idx);
      exp_q.push_back({~m_pat, ~m_dv, m_dig, (t % FR == 0)});
      if ((t + 1) % FR == 0) begin
        m_dp_code  = m_sh_code;
        m_dp_dp    = m_sh_dp;
        m_dp_blink = m_sh_blink;
      end
      if (load) begin
        m_sh_code  = digits_in;
        m_sh_dp    = dp_in;
        m_sh_blink = blink_in;
      end
      t = t + 1;
    end
  end

  int passed = 0;
  int total  = 0;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {seg, dp, dig_sel, frame_tick};
      total++;
      if (mon_act === mon_exp) passed++;
      else $display("FAIL pins t=%0d got seg/dp/dig/ft=%b required=%b",
                    t, mon_act, mon_exp);
    end
  end

  task automatic do_load(input logic [5*N-1:0] d, input logic [N-1:0] p,
                         input logic [N-1:0] b);
    digits_in = d;
    dp_in     = p;
    blink_in  = b;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 4 * FR && (t % FR) != ph; i++) @(negedge clk);
  endtask

  function automatic logic [5*N-1:0] rand_digits();
    logic [5*N-1:0] d;
    for (int k = 0; k < N; k++) d[5*k +: 5] = 5'($urandom_range(0, 31));
    return d;
  endfunction

  logic [5*N-1:0] d_tmp;

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '1; dp_in = '0; blink_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FR + 4) @(negedge clk);

    // scan order with known digits
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, '0, '0);
    repeat (2 * FR) @(negedge clk);

    // tear-free: mid-frame load, then a load exactly on the boundary edge
    wait_phase(6);
    do_load({5'd3, 5'd2, 5'd1, 5'd16}, '0, '0);
    repeat (2 * FR) @(negedge clk);
    wait_phase(FR - 1);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, '0, '0);
    repeat (FR + 3) @(negedge clk);
    wait_phase(FR - 1);
    do_load({5'd3, 5'd2, 5'd1, 5'd16}, '0, '0);
    repeat (3 * FR) @(negedge clk);

    // blink on digit 0 only
    d_tmp = rand_digits();
    d_tmp[4:0] = 5'd8;
    do_load(d_tmp, 4'($urandom_range(0, 15)), 4'b0001);
    repeat (10 * FR) @(negedge clk);

    // all codes on digit 0 with dp requested
    for (int c = 0; c < 32; c++) begin
      d_tmp = rand_digits();
      d_tmp[4:0] = 5'(c);
      do_load(d_tmp, {3'($urandom_range(0, 7)), 1'b1}, 4'($urandom_range(0, 1)));
      repeat (FR + $urandom_range(0, FR)) @(negedge clk);
    end

    // random loads, including back-to-back
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3)
        do_load(rand_digits(), 4'($urandom), 4'($urandom));
      else
        @(negedge clk);
    end
    do_load(rand_digits(), 4'($urandom), 4'($urandom));
    do_load(rand_digits(), 4'($urandom), 4'($urandom));
    repeat (2 * FR) @(negedge clk);

    // reset in the middle of slot 2
    wait_phase(2 * RD + 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FR + 2) @(negedge clk);

    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sevenseg_mux_driver.md
Name: sevenseg_mux_driver

Overview:
- Parametrised, time-multiplexed driver for N common-segment seven-segment digits; successor to the single-digit combinational decoder.
- Decodes full hex 0–F, dash and blank per digit, with a per-digit decimal point.
- Scans digits with a programmable refresh rate, an anti-ghosting guard interval, per-digit blinking, and tear-free frame-synchronous updates.
- Sits between the application logic and the board display pins.

Parameters:
- N_DIGITS, 4: number of digits, legal range 1–8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be greater than GUARD_CYCLES.
- GUARD_CYCLES, 2: cycles at the start of each slot during which all digit enables are inactive.
- BLINK_FRAMES, 50: frames per blink half-period; must be at least 1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the pins.
- DIG_ACTIVE_LOW, 1: 1 inverts dig_sel at the pins.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous reset, active-low.
- digits_in, input, 5*N_DIGITS: per-digit code. Digit k uses bits [5k+4:5k]. Codes 0–15 are hex, 16 is dash, 17–31 are blank.
- dp_in, input, N_DIGITS: per-digit decimal point request.
- blink_in, input, N_DIGITS: per-digit blink enable.
- load, input, 1: capture strobe for digits_in, dp_in and blink_in.
- seg, output, 7: segments {a,b,c,d,e,f,g}, with seg[6]=a and seg[0]=g.
- dp, output, 1: decimal point segment.
- dig_sel, output, N_DIGITS: one-hot digit enable; bit k drives digit k.
- frame_tick, output, 1: single-cycle pulse at each frame start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, index=0, blink counter=0, blink_phase=0.
  - Shadow and display registers: every code=31 (blank), dp=0, blink=0.
  - Outputs: seg and dp inactive (all-off at pin polarity), dig_sel all inactive, frame_tick=0.
  - Reset mid-scan aborts the scan immediately, with no partial frame completion.
- Capture: when load=1 at an edge, the shadow register takes digits_in, dp_in and blink_in. Back-to-back loads keep the last value.
- Prescaler: counts 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and index advances modulo N_DIGITS.
- Frame boundary: occurs when index wraps from N_DIGITS-1 to 0. With N_DIGITS=1 it occurs every slot.
  - At the frame boundary, display register <= shadow, as the shadow stood before that edge.
  - If load coincides with the boundary, the new data appears one frame later. There is no bypass, and no mid-frame change ever reaches the pins.
- frame_tick: high for the one cycle in which outputs first show slot 0 of a new frame.
- Blink: the blink counter counts frame boundaries 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
  - While blink_phase=1, any digit with its display blink bit set shows seg=off and dp=off. Its dig_sel still asserts.
- Guard: while prescaler < GUARD_CYCLES, dig_sel is all inactive. seg and dp already show the new digit's pattern.
- Decode (active-high, before polarity):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - dash=0000001, blank=0000000
- Polarity: applied at the final output stage only.
- Output timing: all outputs are registered. Pins reflect the prescaler, index and blink state of the previous cycle, giving a fixed 1-cycle latency.
- Timing summary: frame period = N_DIGITS*REFRESH_DIV cycles. Blink period = 2*BLINK_FRAMES frames.

Test Plan:
- Reset values, with defaults: hold rst_n=0 for 3 cycles, then release.
  - Required: seg=0000000, dp=0, dig_sel=1111, frame_tick=0 throughout reset.
  - First frame shows all digits blank.
- Scan order, with N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, DIG_ACTIVE_LOW=0:
  - Stimulus: load digits {3,2,1,0} (digit3..digit0).
  - Required: each 4-cycle slot shows dig_sel=0000 for 1 cycle, then 3 cycles of 0001/0010/0100/1000 with seg=1111110/0110000/1101101/1111001.
  - frame_tick pulses every 16 cycles.
- Tear-free update: pulse load with digit0=16 mid-frame, and again exactly at a frame boundary.
  - Required: the dash (0000001) first appears at the next frame start in the mid-frame case, and one frame later in the boundary case.
- Blink, with BLINK_FRAMES=2: set blink_in=0001 and digit0=8.
  - Required: digit0 shows 1111111 for 2 frames, then 0000000 with dig_sel still active for 2 frames, repeating.
  - Other digits are unaffected.
- Polarity and codes, with SEG_ACTIVE_LOW=1: cycle digit0 through codes 0–31 with dp_in=1.
  - Required: seg equals the bitwise inverse of the decode table, and codes 17–31 give seg=1111111.
  - dp=0 (active) except while blanked.
- Reset mid-scan: assert rst_n=0 during slot 2.
  - Required: next edge gives dig_sel all inactive. After release, the scan restarts at digit 0 with blank contents.
